seq_subtractor: RTL and testbench
=================================

Name: seq_subtractor

Overview:
Multi-cycle 64-bit two's-complement subtractor, the inverse operation of the datapath's ripple adder. It computes diff = a - b as a + ~b + 1, processing one 4-bit digit per clock, LSB digit first. It reports unsigned borrow and signed overflow, and uses a start/busy/done handshake. It sits beside the adder in the ALU and trades latency for one shared 4-bit slice.

Parameters:
WIDTH, 64, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle.
(Derived: STEPS = WIDTH/DIGIT = 16.)

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  minuend; captured on the accepted start edge.
b  input  WIDTH  subtrahend; captured on the accepted start edge.
busy  output  1  high while digits are being computed.
done  output  1  one-cycle pulse when a result is valid.
diff  output  WIDTH  result a - b, modulo 2^WIDTH.
borrow  output  1  1 when unsigned a < b (inverted final carry).
overflow  output  1  signed overflow of a - b.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy, done, diff, borrow, overflow all 0.
  - Internal operand, partial-result and digit-index registers are cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge T0 captures a, b, sets carry=1, index=0, goes to RUN. busy=1 from T0.
- RUN: at each edge T1..T16, digit[index] = a_dig + ~b_dig + carry (DIGIT-bit sum plus carry-out).
  - The sum is written into the partial result; carry is updated; index increments.
  - On the edge that completes index=STEPS-1 (T16), the state moves to DONE.
  - At the same edge: diff <= full partial result; borrow <= ~carry_out; overflow <= (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
- DONE: busy=0, done=1 for exactly one cycle (between T16 and T17).
  - start=1 at T17 is accepted exactly as from IDLE (back-to-back operation), so the next result's done appears at T33.
  - Otherwise the state returns to IDLE.
- Latency: done is high in the 17th cycle after the start edge; throughput is one result per 17 cycles.
- start while busy=1 is ignored. Captured operands are unaffected and no request is queued.
- a and b may change freely after the accepted start edge.
- diff, borrow and overflow update only at the completion edge. They hold the previous result (or reset 0) during RUN and stay stable until the next completion or reset.
- Width rules:
  - Carry chains across digits through the internal carry register; the initial carry is 1 (the two's-complement +1).
  - The final carry-out is not part of diff; it is reported only as ~borrow.

Test Plan:
- Basic: a=5, b=3, start one cycle -> busy for 16 cycles; done at cycle 17; diff=2, borrow=0, overflow=0; busy low during the done cycle.
- Underflow: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1, overflow=0.
- Signed overflow: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, borrow=0, overflow=1. Then a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, borrow=1, overflow=1.
- Full ripple: a=0x0000_0001_0000_0000, b=1 -> diff=0x0000_0000_FFFF_FFFF. Check that diff keeps its previous value until the done cycle.
- Handshake:
  - start pulsed again at cycle 5 with a=9, b=9 -> ignored; the first result is unchanged.
  - start held in the done cycle with a=10, b=4 -> second done exactly 17 cycles later with diff=6.
- Reset mid-operation: drop rst_n at cycle 8 (asynchronously, between edges) -> all outputs 0 immediately. No done pulse afterwards. A fresh start after release gives correct results (a=100, b=58 -> diff=42).

Source files
------------

// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle two's-complement subtractor, diff = a + ~b + 1,
// computed one DIGIT-bit slice per clock, least significant digit first.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only while not busy
//   a, b            minuend / subtrahend, captured on the accepted start edge
//   busy            high while digits are being computed
//   done            one-cycle pulse when diff/borrow/overflow are updated
//   diff            a - b modulo 2^WIDTH
//   borrow          unsigned a < b (inverted final carry-out)
//   overflow        signed overflow of a - b
module seq_subtractor #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned MSB   = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [WIDTH-1:0]   r_res, w_res_nxt;
    logic               r_carry, w_carry_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [WIDTH-1:0]   r_diff, w_diff_nxt;
    logic               r_borrow, w_borrow_nxt;
    logic               r_overflow, w_overflow_nxt;

    logic [SEL_W-1:0]   w_base;
    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_nb_dig;
    logic [DIGIT:0]     w_dig_sum;
    logic [WIDTH-1:0]   w_res_upd;

    // Shared digit slice: a_dig + ~b_dig + carry, carry-out in the top bit.
    assign w_base    = SEL_W'(r_idx) * SEL_W'(DIGIT);
    assign w_a_dig   = r_a[w_base +: DIGIT];
    assign w_nb_dig  = ~r_b[w_base +: DIGIT];
    assign w_dig_sum = (DIGIT+1)'(w_a_dig) + (DIGIT+1)'(w_nb_dig) + (DIGIT+1)'(r_carry);

    // Partial result with the current digit merged in.
    always_comb begin
        w_res_upd = r_res;
        w_res_upd[w_base +: DIGIT] = w_dig_sum[DIGIT-1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_res_nxt      = r_res;
        w_carry_nxt    = r_carry;
        w_idx_nxt      = r_idx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_diff_nxt     = r_diff;
        w_borrow_nxt   = r_borrow;
        w_overflow_nxt = r_overflow;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_res_nxt   = '0;
                    w_carry_nxt = 1'b1;   // the +1 of two's-complement negation
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_res_nxt   = w_res_upd;
                w_carry_nxt = w_dig_sum[DIGIT];
                w_idx_nxt   = IDX_W'(r_idx + 1'b1);
                if (r_idx == IDX_W'(STEPS - 1)) begin
                    w_state_nxt    = S_DONE;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_diff_nxt     = w_res_upd;
                    w_borrow_nxt   = ~w_dig_sum[DIGIT];
                    w_overflow_nxt = (r_a[MSB] != r_b[MSB]) && (w_res_upd[MSB] != r_a[MSB]);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_res      <= w_res_nxt;
            r_carry    <= w_carry_nxt;
            r_idx      <= w_idx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_diff     <= w_diff_nxt;
            r_borrow   <= w_borrow_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign diff     = r_diff;
    assign borrow   = r_borrow;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor: hand-computed vectors, latency,
// handshake and asynchronous-reset behaviour.
module tb_seq_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        borrow;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int n;
    int done_cnt;

    seq_subtractor #(.WIDTH(64), .DIGIT(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge, then scramble the operand inputs.
    task automatic start_op(input logic [63:0] ta, input logic [63:0] tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_after_start", 64'(done), 64'd0);
    endtask

    // Wait (bounded) for done; while running, busy must stay high and diff must hold.
    task automatic wait_done(input logic [63:0] hold, output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (done) break;
            chk("busy_run", 64'(busy), 64'd1);
            chk("diff_hold", diff, hold);
        end
        if (!done) chk("timeout_done", 64'd0, 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic chk_result(input string tag, input logic [63:0] d, input logic br, input logic ov);
        chk({tag, "_diff"}, diff, d);
        chk({tag, "_borrow"}, 64'(borrow), 64'(br));
        chk({tag, "_ovf"}, 64'(overflow), 64'(ov));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_result("rst", 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic: 5 - 3
        start_op(64'd5, 64'd3);
        wait_done(64'd0, n);
        chk("basic_latency", 64'(n), 64'd16);
        chk_result("basic", 64'd2, 1'b0, 1'b0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("diff_stable", diff, 64'd2);

        // Underflow: 0 - 1
        start_op(64'd0, 64'd1);
        wait_done(64'd2, n);
        chk_result("underflow", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        tick();

        // Signed overflow, negative minus positive
        start_op(64'h8000_0000_0000_0000, 64'd1);
        wait_done(64'hFFFF_FFFF_FFFF_FFFF, n);
        chk_result("ovf_neg", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        tick();

        // Signed overflow, positive minus negative
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(64'h7FFF_FFFF_FFFF_FFFF, n);
        chk_result("ovf_pos", 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        tick();

        // Full ripple of a borrow across eight digits
        start_op(64'h0000_0001_0000_0000, 64'd1);
        wait_done(64'h8000_0000_0000_0000, n);
        chk_result("ripple", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        tick();

        // Handshake: a start while busy is ignored
        start_op(64'd20, 64'd7);
        repeat (4) tick();
        a     = 64'd9;
        b     = 64'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(64'h0000_0000_FFFF_FFFF, n);
        chk("ignored_latency", 64'(5 + n), 64'd16);
        chk_result("ignored", 64'd13, 1'b0, 1'b0);

        // Back-to-back: start held in the done cycle
        a     = 64'd10;
        b     = 64'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 64'd0;
        b     = 64'd0;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_done_low", 64'(done), 64'd0);
        wait_done(64'd13, n);
        chk("b2b_latency", 64'(n), 64'd16);
        chk_result("b2b", 64'd6, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of an operation
        start_op(64'h55, 64'h11);
        repeat (7) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk_result("arst", 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        chk("arst_idle_busy", 64'(busy), 64'd0);

        // Fresh operation after reset release
        start_op(64'd100, 64'd58);
        wait_done(64'd0, n);
        chk("post_rst_latency", 64'(n), 64'd16);
        chk_result("post_rst", 64'd42, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
